// File: rtl/sr_drive_ctrl.sv
// Drives S/R of an external SR latch from a request handshake.
// The pulse is non-overlapping and followed by a settle window and a synchronized feedback check.
// Optional: define SR_DRIVE_SKIP_EN to complete requests immediately when the latch already holds the value.
module sr_drive_ctrl #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_val,
    output logic S,
    output logic R,
    input  logic q_fb,
    input  logic q_not_fb,
    output logic done,
    output logic err,
    output logic q_sync
);

    localparam int MAX_P = (PULSE_W > SETTLE)
                         ? ((PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT)
                         : ((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT);
    localparam int CW = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          req_val_r;
    logic          q_s1;
    logic          q_not_s1;
    logic          q_not_sync;
    logic          fb_match;
    logic          skip_hit;

    assign fb_match = (q_sync == req_val_r) && (q_not_sync == ~req_val_r);

`ifdef SR_DRIVE_SKIP_EN
    assign skip_hit = (q_sync == req_val) && (q_not_sync == ~req_val);
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_val_r  <= 1'b0;
            S          <= 1'b0;
            R          <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            req_ready  <= 1'b0;
            q_s1       <= 1'b0;
            q_sync     <= 1'b0;
            q_not_s1   <= 1'b0;
            q_not_sync <= 1'b0;
        end else begin
            q_s1       <= q_fb;
            q_sync     <= q_s1;
            q_not_s1   <= q_not_fb;
            q_not_sync <= q_not_s1;
            done       <= 1'b0;
            err        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    S         <= 1'b0;
                    R         <= 1'b0;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_val_r <= req_val;
                        if (skip_hit) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ST_PULSE;
                            cnt       <= PULSE_LOAD;
                            S         <= req_val;
                            R         <= ~req_val;
                            req_ready <= 1'b0;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LOAD;
                        S     <= 1'b0;
                        R     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                        cnt   <= TIMEOUT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    // A match wins over timeout on the final CHECK cycle.
                    if (fb_match) begin
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else if (cnt == '0) begin
                        err       <= 1'b1;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl with a behavioural SR latch and a per-request timing model.
// Honours SR_DRIVE_SKIP_EN when it is defined for the build.
module tb_sr_drive_ctrl;

    localparam int PW = 2;
    localparam int ST = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic req_ready, S, R, done, err, q_sync;
    logic q_fb, q_not_fb;

    bit lq = 1'b0;
    bit stuck = 1'b0;
    int n_cmp = 0;
    int n_mis = 0;

    assign q_fb     = stuck ? 1'b0 : lq;
    assign q_not_fb = stuck ? 1'b0 : ~lq;

    always #5 clk = ~clk;

    // Latch model: Q follows S/R within the cycle they are driven.
    always @(negedge clk) begin
        if (S === 1'b1)      lq <= 1'b1;
        else if (R === 1'b1) lq <= 1'b0;
    end

    sr_drive_ctrl #(.PULSE_W(PW), .SETTLE(ST), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_val(req_val), .S(S), .R(R), .q_fb(q_fb), .q_not_fb(q_not_fb),
        .done(done), .err(err), .q_sync(q_sync)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle index of the done/err pulse after an accept (offset 1 = first cycle after the accept edge).
    function automatic int end_k(bit ok, bit skip);
        if (skip) return 1;
        return ok ? (PW + ST + 2) : (PW + ST + 1 + TO);
    endfunction

    // Expected {S,R,done,err,req_ready} in cycle T+k.
    function automatic logic [4:0] exp_vec(int k, bit val, bit ok, bit skip);
        int e;
        e = end_k(ok, skip);
        if (skip) return 5'b00101;
        return {val && (k <= PW), !val && (k <= PW), ok && (k == e), !ok && (k == e), k == e};
    endfunction

    function automatic bit predict_skip(bit val);
`ifdef SR_DRIVE_SKIP_EN
        return !stuck && (lq == val);
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0;
        repeat (3) step();
        got = {S, R, done, err, req_ready};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_mis++;
            $display("FAIL reset_outputs got=%b exp=%b", got, 5'b00000);
        end
        n_cmp++;
        if (q_sync !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_q_sync got=%b exp=0", q_sync);
        end
        rst_n = 1'b1;
        step();
        got = {S, R, done, err, req_ready};
        n_cmp++;
        if (got !== 5'b00001) begin
            n_mis++;
            $display("FAIL reset_release got=%b exp=%b", got, 5'b00001);
        end
    endtask

    // One request from an idle controller; optional noise on req_valid/req_val while busy.
    task automatic test_request(input string name, input bit val, input bit noise);
        bit ok, skip;
        int e;
        logic [4:0] got, expv;
        ok   = !stuck;
        skip = predict_skip(val);
        e    = end_k(ok, skip);
        req_val   = val;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= e; k++) begin
            got  = {S, R, done, err, req_ready};
            expv = exp_vec(k, val, ok, skip);
            n_cmp++;
            if (got !== expv) begin
                n_mis++;
                $display("FAIL %s k=%0d {S,R,done,err,ready} got=%b exp=%b", name, k, got, expv);
            end
            if (ok && k == e) begin
                n_cmp++;
                if (q_sync !== val) begin
                    n_mis++;
                    $display("FAIL %s_q_sync got=%b exp=%b", name, q_sync, val);
                end
            end
            if (k < e) begin
                req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                req_val   = 1'($urandom_range(0, 1));
                step();
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_set_clear_stuck();
        test_request("set", 1'b1, 1'b0);
        test_request("clear", 1'b0, 1'b0);
        stuck = 1'b1;
        repeat (3) step();
        test_request("stuck", 1'b1, 1'b0);
        stuck = 1'b0;
        repeat (3) step();
        test_request("already_set", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_pulse();
        logic [4:0] got;
        bit val;
        val = !lq;
        req_val   = val;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        got = {S, R, done, err, req_ready};
        n_cmp++;
        if (got !== {val, !val, 3'b000}) begin
            n_mis++;
            $display("FAIL midrst_pulse got=%b exp=%b", got, {val, !val, 3'b000});
        end
        rst_n = 1'b0;
        step();
        got = {S, R, done, err, req_ready};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_mis++;
            $display("FAIL midrst_abort got=%b exp=%b", got, 5'b00000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            got = {S, R, done, err, req_ready};
            n_cmp++;
            if (got !== 5'b00001) begin
                n_mis++;
                $display("FAIL midrst_after i=%0d got=%b exp=%b", i, got, 5'b00001);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, expv;
        bit val;
        int e;
        e   = end_k(1'b1, 1'b0);
        val = !lq;
        req_val   = val;
        req_valid = 1'b1;
        step();
        for (int t = 0; t < 2; t++) begin
            for (int k = 1; k <= e; k++) begin
                got  = {S, R, done, err, req_ready};
                expv = exp_vec(k, val, 1'b1, 1'b0);
                n_cmp++;
                if (got !== expv || (S & R) !== 1'b0) begin
                    n_mis++;
                    $display("FAIL b2b t=%0d k=%0d got=%b exp=%b", t, k, got, expv);
                end
                if (k < e) step();
            end
            val     = !val;
            req_val = val;
            if (t == 0) step();
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [4:0] got;
        for (int n = 0; n < 30; n++) begin
            stuck = ($urandom_range(0, 4) == 0);
            for (int g = 0; g < int'($urandom_range(3, 5)); g++) begin
                step();
                got = {S, R, done, err, req_ready};
                n_cmp++;
                if (got !== 5'b00001) begin
                    n_mis++;
                    $display("FAIL rand_idle n=%0d got=%b exp=%b", n, got, 5'b00001);
                end
            end
            test_request("rand", 1'($urandom_range(0, 1)), 1'b1);
        end
        stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_clear_stuck();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
